// File: rtl/instr_prefetch_queue.sv
// Fetch front end: request/response instruction fetcher feeding a small {PC, instruction}
// FIFO whose head drives the IF/ID stage; supports decode stall and branch redirect/flush.
module instr_prefetch_queue #(
  parameter int unsigned PC_W  = 9,
  parameter int unsigned INS_W = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic                     imem_rvalid,
  input  logic [INS_W-1:0]         imem_rdata,
  output logic                     if_valid,
  output logic [PC_W-1:0]          if_pc,
  output logic [INS_W-1:0]         if_instr,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  logic [PC_W-1:0]    r_fetch_pc;
  logic [PC_W-1:0]    r_pc_mem  [DEPTH];
  logic [INS_W-1:0]   r_ins_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_not_empty;
  logic               w_not_full;
  logic               w_req;
  logic               w_push;
  logic               w_pop;

  assign w_not_empty = (r_count != '0);
  assign w_not_full  = (r_count < CNT_W'(DEPTH));

  // Request is held low while reset is asserted so nothing leaks out during reset.
  assign w_req  = !reset && (r_state == S_FETCH) && w_not_full && !redirect;
  assign w_push = (r_state == S_WAIT) && imem_rvalid && !redirect;
  assign w_pop  = w_not_empty && !stall && !redirect;

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;

  // Empty head reads as PC 0 / instruction 0, which downstream treats as a bubble.
  assign if_valid = w_not_empty;
  assign if_pc    = w_not_empty ? r_pc_mem[r_rd_ptr]  : '0;
  assign if_instr = w_not_empty ? r_ins_mem[r_rd_ptr] : '0;
  assign q_count  = r_count;

  // Fetch sequencer; a redirect with a response still in flight parks in DRAIN to eat it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      case (r_state)
        S_WAIT:  r_state <= imem_rvalid ? S_FETCH : S_DRAIN;
        S_DRAIN: r_state <= imem_rvalid ? S_FETCH : S_DRAIN;
        default: r_state <= S_FETCH;
      endcase
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_req) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_fetch_pc <= r_fetch_pc + PC_W'(4);
            r_state    <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) begin
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // FIFO pointers and occupancy; a redirect flushes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; the PC recorded is the address the data was fetched from.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]  <= r_fetch_pc;
      r_ins_mem[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule
